mux_scan_ctrl: RTL and testbench

Sequencing controller for one sn74151 8-to-1 data selector. It drives the mux select lines and strobe and samples the Z output once per channel. It assembles the eight sampled levels into a parallel word and delivers that word over a valid/ready handshake. The block turns the 74151 into a scanned 8-bit input port for downstream logic. It supports single-shot and continuous scanning, with backpressure.

---
 rtl/mux_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for an sn74151 8:1 selector: steps SEL 0..7, samples Z per channel, delivers the byte on valid/ready.
// Optional change-detect IRQ is built when MUX_SCAN_IRQ_EN is defined; otherwise irq_o is tied low.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       cont_i,
    output logic [2:0] sel_o,
    output logic       e_n_o,
    input  logic       z_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_t;

    localparam logic       ZERO_SETTLE = (SETTLE == 0);
    localparam logic [3:0] CNT_LAST    = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic       e_n_q, e_n_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [7:0] word_w;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            e_n_q   <= 1'b1;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            e_n_q   <= e_n_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        e_n_d   = e_n_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        // Word as it will look once the current channel's level is merged in
        word_w         = shreg_q;
        word_w[sel_q]  = z_i;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sel_d   = 3'd0;
                    e_n_d   = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = ZERO_SETTLE ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                shreg_d = word_w;
                cnt_d   = 4'd0;
                if (sel_q != 3'd7) begin
                    sel_d   = sel_q + 3'd1;
                    state_d = ZERO_SETTLE ? S_SAMPLE : S_SETTLE;
                end else begin
                    data_d  = word_w;
                    valid_d = 1'b1;
                    e_n_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    sel_d   = 3'd0;
                    if (cont_i) begin
                        e_n_d   = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = ZERO_SETTLE ? S_SAMPLE : S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MUX_SCAN_IRQ_EN
    logic       hold_entry;
    logic [7:0] prev_q;
    logic       irq_q;

    assign hold_entry = (state_q == S_SAMPLE) && (sel_q == 3'd7);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 8'h00;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= hold_entry && (word_w != prev_q);
            if (hold_entry) prev_q <= word_w;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign sel_o   = sel_q;
    assign e_n_o   = e_n_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a 74151 model drives Z, a monitor pops expected words on each handshake.
module tb_mux_scan_ctrl;
    localparam int S    = 2;
    localparam int SCAN = 8 * (S + 1);

    typedef struct {
        logic [7:0] word;
        int         t0;
    } item_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cont = 1'b0, ready = 1'b1;
    logic       z, e_n, valid, busy, irq;
    logic [2:0] sel;
    logic [7:0] data, mux_in = 8'h00;
    logic       start0 = 1'b0, z0, e_n0, valid0, busy0, irq0;
    logic [2:0] sel0;
    logic [7:0] data0;

    int    checks = 0, failures = 0, cyc = 0;
    item_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 74151: Z follows the selected input while strobed, low otherwise
    assign z  = ~e_n  & mux_in[sel];
    assign z0 = ~e_n0 & mux_in[sel0];

    mux_scan_ctrl #(.SETTLE(S)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .sel_o(sel), .e_n_o(e_n),
        .z_i(z), .data_o(data), .valid_o(valid), .ready_i(ready), .busy_o(busy), .irq_o(irq));

    mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .cont_i(1'b0), .sel_o(sel0), .e_n_o(e_n0),
        .z_i(z0), .data_o(data0), .valid_o(valid0), .ready_i(1'b1), .busy_o(busy0), .irq_o(irq0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic scan_checked(input logic [7:0] w);
        mux_in = w;
        sb.push_back('{word: w, t0: cyc + 1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < SCAN; k++) begin
            chk("sel_step", sel, k / (S + 1));
            chk("e_n_scan", e_n, 0);
            chk("busy_scan", busy, 1);
            @(negedge clk);
        end
        chk("valid_rise", valid, 1);
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while (!valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("valid_timeout", valid, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            i++;
        end
        ready = 1'b1;
        if (busy) @(negedge clk);
        @(negedge clk);
        chk("idle_timeout", busy, 0);
    endtask

    initial begin : monitor
        logic  prev_v, prev_hs, prev_rst, exp_irq;
        int    rise;
        item_t it;
`ifdef MUX_SCAN_IRQ_EN
        logic [7:0] last_word = 8'h00;
`endif
        prev_v = 1'b0; prev_hs = 1'b0; prev_rst = 1'b1; rise = 0;
        forever begin
            @(negedge clk);
            #1;
            exp_irq = 1'b0;
            if (prev_v && !valid) chk("valid_drop", {31'b0, prev_hs | prev_rst}, 1);
            if (valid && !prev_v) begin
                rise = cyc;
                chk("valid_expected", {31'b0, sb.size() != 0}, 1);
`ifdef MUX_SCAN_IRQ_EN
                if (sb.size() != 0) begin
                    exp_irq   = (sb[0].word != last_word);
                    last_word = sb[0].word;
                end
`endif
            end
            chk("irq", irq, exp_irq);
`ifdef MUX_SCAN_IRQ_EN
            if (rst) last_word = 8'h00;
`endif
            if (valid && ready && sb.size() != 0) begin
                it = sb.pop_front();
                chk("data", data, it.word);
                chk("latency", rise - it.t0, SCAN);
            end
            prev_hs  = valid && ready;
            prev_v   = valid;
            prev_rst = rst;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [7:0] cw [4];
        int r, r_prev, t0, n;
        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_e_n", e_n, 1);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single scan, consumer always ready
        scan_checked(8'hA5);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_e_n", e_n, 1);
        chk("idle_sel", sel, 0);
        chk("idle_valid", valid, 0);

        // Backpressure with an ignored START during HOLD
        ready = 1'b0;
        scan_checked(8'hA5);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", valid, 1);
            chk("hold_data", data, 8'hA5);
            chk("hold_sel", sel, 7);
            chk("hold_e_n", e_n, 1);
            start = (i == 3);
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("after_hs_busy", busy, 0);
            chk("after_hs_e_n", e_n, 1);
            @(negedge clk);
        end

        scan_checked(8'h5A);
        @(negedge clk);

        // Random words with random READY stalls
        repeat (4) begin
            scan_checked(8'($urandom));
            wait_idle(60);
        end

        // Continuous mode: back-to-back words
        cw[0] = 8'h3C; cw[1] = 8'hC3; cw[2] = 8'($urandom); cw[3] = 8'($urandom);
        cont = 1'b1; ready = 1'b1;
        mux_in = cw[0];
        sb.push_back('{word: cw[0], t0: cyc + 1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(SCAN + 4);
            r = cyc;
            if (k > 0) chk("cont_period", r - r_prev, SCAN + 1);
            r_prev = r;
            if (k < 3) begin
                mux_in = cw[k + 1];
                sb.push_back('{word: cw[k + 1], t0: cyc + 1});
            end else begin
                cont = 1'b0;
            end
            @(negedge clk);
        end
        chk("cont_idle", busy, 0);

        // Reset in the middle of a scan
        mux_in = 8'($urandom);
        sb.push_back('{word: mux_in, t0: cyc + 1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sel != 3'd4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sel4", sel, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_e_n", e_n, 1);
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_irq", irq, 0);
        for (int i = 0; i < SCAN + 8; i++) begin
            chk("no_valid_after_rst", valid, 0);
            @(negedge clk);
        end
        scan_checked(8'($urandom));
        @(negedge clk);

        // SETTLE=0 instance
        mux_in = 8'hFF;
        start0 = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s0_valid", valid0, 1);
        chk("s0_latency", cyc - t0, 8);
        chk("s0_data", data0, 8'hFF);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
